uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: accepts parallel words through a valid/ready handshake and serialises them LSB-first as 8N1-style frames on a single line. It has optional parity, 1 or 2 stop bits, and a one-entry holding register so consecutive frames go out with no idle gap. It is the transmit-side counterpart of the team's UART receiver and shares its parameter set and handshake convention.

## Interface
- DATA_WIDTH, 8, bits per frame payload
- BAUD_RATE, 9600, line bit rate
- CLK_FREQ, 12_000_000, clk frequency in Hz
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, number of stop bits; 1 or 2
- Derived: PULSE_WIDTH = CLK_FREQ / BAUD_RATE (integer division), clk cycles per bit. Elaboration error if PULSE_WIDTH < 2, PARITY > 2 or STOP_BITS not in {1,2}.
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- data  in  DATA_WIDTH  word to send
- valid  in  1  data valid
- ready  out  1  holding register empty; word accepted when valid && ready at clk edge
- sig  out  1  serial line, idle high, registered
- busy  out  1  frame in progress or word held

## Operation
- Reset values: sig=1, ready=1, busy=0. Holding register empty, state STT_IDLE, counters 0.
- Holding register: loaded on valid && ready. ready = !hold_full. The register is cleared when the shifter takes its contents.
- FSM states: STT_IDLE, STT_START, STT_DATA, STT_PARITY, STT_STOP.
- STT_IDLE, hold_full: load the shift register, compute parity, clear hold, sig<=0, go to STT_START.
- STT_START: sig=0 for PULSE_WIDTH cycles, then go to STT_DATA.
- STT_DATA: sig = shift[0] for PULSE_WIDTH cycles per bit, LSB first, DATA_WIDTH bits.
- After STT_DATA: go to STT_PARITY if PARITY!=0, else STT_STOP.
- STT_PARITY: drive the parity bit for one bit time.
  - even mode: parity = ^data.
  - odd mode: parity = ~^data.
- STT_STOP: sig=1 for STOP_BITS*PULSE_WIDTH cycles.
  - On the final cycle with hold_full: load directly and go to STT_START (sig<=0 at the next edge). No idle cycles.
  - On the final cycle without hold_full: go to STT_IDLE.
- Bit timer: down-counter, $clog2(PULSE_WIDTH) bits. It reloads with PULSE_WIDTH-1 at each bit boundary and advances at 0.
- Bit counter: $clog2(DATA_WIDTH)+1 bits.
- data is sampled only at acceptance. Changes to data afterwards do not affect the frame.
- busy = (state != STT_IDLE) || hold_full.
- Async reset mid-frame: sig returns to 1 immediately (asynchronously), the frame is truncated, and the held word is discarded.

## Timing
- Accept at edge N (idle shifter): hold_full from N, so ready is low during cycle N→N+1. Start bit begins at edge N+1, and ready is high again after N+1.
- Every bit is exactly PULSE_WIDTH cycles.
- Frame length = (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) * PULSE_WIDTH cycles.
- A word accepted during a frame starts at the edge that ends the previous frame's last stop bit.
- ready is low from the accept edge until that load edge.
- Accept and load cannot coincide. ready is low whenever hold is full, so there is no overwrite case.
- valid held with ready low: no acceptance and no side effect.

## Structure
- Shared package uart_pkg holds:
  - parity enum (PAR_NONE/PAR_ODD/PAR_EVEN)
  - tx state typedef
  - constant function for pulse width
- One sub-module is natural: uart_baud_cnt, a reloadable down-counter with a terminal-count output. The receiver can reuse it.

## Test plan
Run with CLK_FREQ=160, BAUD_RATE=10 (PULSE_WIDTH=16).
- After reset: sig=1, ready=1, busy=0. With valid=0 for 100 cycles, sig stays 1.
- Send 8'hA5, no parity, 1 stop, accept at edge N:
  - sig low over cycles N+1..N+16.
  - Data bits 1,0,1,0,0,1,0,1 at 16 cycles each.
  - Stop bit high for 16 cycles; busy falls 160 cycles after N+1.
- Two words 8'h3C and 8'hC3 offered back-to-back:
  - Second word accepted the cycle after the first loads; ready stays low until the first stop bit ends.
  - Both frames contiguous over 320 cycles, with no high gap beyond the stop bit.
- Parity on 8'h07:
  - PARITY=2 (even): bit after data = 1, frame 176 cycles.
  - PARITY=1 (odd): bit after data = 0.
- STOP_BITS=2, two queued words: sig high for exactly 32 cycles between the last data bit and the next start bit.
- Assert rstn low mid-data of 8'hFF:
  - sig=1 before the next clk edge; ready=1, busy=0.
  - After release, a send of 8'h01 produces a clean, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Contents: parity mode enum, transmitter state enum, pulse width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        STT_IDLE   = 3'd0,
        STT_START  = 3'd1,
        STT_DATA   = 3'd2,
        STT_PARITY = 3'd3,
        STT_STOP   = 3'd4
    } tx_state_e;

    // Clock cycles per line bit.
    function automatic int pulse_width(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - reloadable down-counter with terminal-count flag
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   load, load_val   reload the counter with load_val (takes priority)
//   tc               counter is at zero
// The counter holds at zero until reloaded.
module uart_baud_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with one-entry holding register
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   data        word to send, sampled when valid && ready
//   valid       data valid
//   ready       holding register empty
//   sig         serial line, idle high, registered
//   busy        frame in progress or word held
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 9600,
    parameter int CLK_FREQ   = 12_000_000,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic                  sig,
    output logic                  busy
);

    localparam int PW = pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int TW = (PW > 1) ? $clog2(PW) : 1;
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [TW-1:0] PW_RELOAD = TW'(PW - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (PW < 2) begin : g_bad_pulse_width
        $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (PARITY > 2 || PARITY < 0) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  sig_q, sig_d;

    logic bit_tc;
    logic timer_load;
    logic load_frame;
    logic accept;

    uart_baud_cnt #(
        .WIDTH(TW)
    ) u_bit_timer (
        .clk     (clk),
        .rstn    (rstn),
        .load    (timer_load),
        .load_val(PW_RELOAD),
        .tc      (bit_tc)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        sig_d       = sig_q;
        load_frame  = 1'b0;
        accept      = valid && !hold_full_q;

        case (state_q)
            STT_IDLE: begin
                if (hold_full_q) begin
                    load_frame = 1'b1;
                end
            end
            STT_START: begin
                if (bit_tc) begin
                    state_d   = STT_DATA;
                    sig_d     = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            STT_DATA: begin
                if (bit_tc) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY != int'(PAR_NONE)) begin
                            state_d = STT_PARITY;
                            sig_d   = par_q;
                        end else begin
                            state_d = STT_STOP;
                            sig_d   = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        sig_d     = shift_d[0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STT_PARITY: begin
                if (bit_tc) begin
                    state_d   = STT_STOP;
                    sig_d     = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            STT_STOP: begin
                if (bit_tc) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        // A held word starts on the very next edge: no idle gap.
                        if (hold_full_q) begin
                            load_frame = 1'b1;
                        end else begin
                            state_d = STT_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = STT_IDLE;
                sig_d   = 1'b1;
            end
        endcase

        if (load_frame) begin
            state_d     = STT_START;
            shift_d     = hold_q;
            par_d       = (PARITY == int'(PAR_EVEN)) ? ^hold_q : ~^hold_q;
            hold_full_d = 1'b0;
            sig_d       = 1'b0;
        end

        // Accept needs an empty holding register and load needs a full one,
        // so the two never happen on the same edge.
        if (accept) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end

        // Reload at every bit boundary, except when the line goes idle so the
        // timer rests at zero and a new word can start on the next edge.
        timer_load = bit_tc && (state_d != STT_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= STT_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            sig_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bit_cnt_q   <= bit_cnt_d;
            sig_q       <= sig_d;
        end
    end

    assign ready = !hold_full_q;
    assign sig   = sig_q;
    assign busy  = (state_q != STT_IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx over four parity/stop configurations
module tb_uart_tx;

    localparam int NI = 4;
    localparam int PW = 16;
    localparam int PAR_C  [NI] = '{0, 2, 1, 0};
    localparam int STOP_C [NI] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] din [NI];
    logic       vin [NI];
    logic       rdy [NI];
    logic       sig [NI];
    logic       bsy [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx #(
            .DATA_WIDTH(8),
            .BAUD_RATE (10),
            .CLK_FREQ  (160),
            .PARITY    (PAR_C[g]),
            .STOP_BITS (STOP_C[g])
        ) u_dut (
            .clk  (clk),
            .rstn (rstn),
            .data (din[g]),
            .valid(vin[g]),
            .ready(rdy[g]),
            .sig  (sig[g]),
            .busy (bsy[g])
        );
    end

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: each accepted word becomes a list of per-cycle line
    // levels appended to a queue; one level is consumed per clock edge.
    bit mq_bit   [NI][$];
    bit mq_first [NI][$];
    int pend     [NI];
    bit exp_sig  [NI];
    bit exp_rdy  [NI];
    bit exp_busy [NI];

    function automatic void model_clear(input int i);
        mq_bit[i].delete();
        mq_first[i].delete();
        pend[i]     = 0;
        exp_sig[i]  = 1'b1;
        exp_rdy[i]  = 1'b1;
        exp_busy[i] = 1'b0;
    endfunction

    function automatic void push_frame(input int i, input logic [7:0] d);
        int nbits;
        bit b;
        nbits = 1 + 8 + ((PAR_C[i] != 0) ? 1 : 0) + STOP_C[i];
        for (int k = 0; k < nbits; k++) begin
            if (k == 0)                          b = 1'b0;
            else if (k <= 8)                     b = d[k-1];
            else if (k == 9 && PAR_C[i] == 2)    b = ^d;
            else if (k == 9 && PAR_C[i] == 1)    b = ~^d;
            else                                 b = 1'b1;
            for (int r = 0; r < PW; r++) begin
                mq_bit[i].push_back(b);
                mq_first[i].push_back(k == 0 && r == 0);
            end
        end
    endfunction

    always @(negedge rstn) begin
        for (int i = 0; i < NI; i++) model_clear(i);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (!rstn) begin
                model_clear(i);
            end else begin
                bit acc;
                bit popped;
                acc    = vin[i] && exp_rdy[i];
                popped = 1'b0;
                if (mq_bit[i].size() != 0) begin
                    exp_sig[i] = mq_bit[i].pop_front();
                    if (mq_first[i].pop_front()) pend[i]--;
                    popped = 1'b1;
                end else begin
                    exp_sig[i] = 1'b1;
                end
                if (acc) begin
                    push_frame(i, din[i]);
                    pend[i]++;
                end
                exp_rdy[i]  = (pend[i] == 0);
                exp_busy[i] = popped || (pend[i] != 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("sig%0d", i),   sig[i], exp_sig[i]);
                chk($sformatf("ready%0d", i), rdy[i], exp_rdy[i]);
                chk($sformatf("busy%0d", i),  bsy[i], exp_busy[i]);
            end
        end
    end

    // Offer one word; returns (at a negedge) with the accept cycle number.
    task automatic send(input int i, input logic [7:0] d, output int acc_cyc);
        bit acc;
        acc = 1'b0;
        vin[i] = 1'b1;
        din[i] = d;
        for (int n = 0; n < 2000 && !acc; n++) begin
            acc = rdy[i];
            @(negedge clk);
        end
        acc_cyc = cyc;
        vin[i] = 1'b0;
        din[i] = 8'($urandom);
        chk($sformatf("send_accept%0d", i), acc, 1);
    endtask

    // Cycles until busy drops, counted from the current negedge.
    task automatic wait_idle(input int i, output int k);
        for (k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (!bsy[i]) break;
        end
    endtask

    task automatic rand_traffic(input int i);
        int acc_c;
        int gap;
        for (int w = 0; w < 10; w++) begin
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 220));
            repeat (gap) @(negedge clk);
            send(i, 8'($urandom), acc_c);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, n2, k, hi;
        rstn = 1'b1;
        for (int i = 0; i < NI; i++) begin
            vin[i] = 1'b0;
            din[i] = 8'h00;
        end
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rstn = 1'b1;

        chk("rst_sig",   sig[0], 1);
        chk("rst_ready", rdy[0], 1);
        chk("rst_busy",  bsy[0], 0);
        repeat (100) @(negedge clk);
        chk("idle_sig", sig[0], 1);

        // Single frame 8'hA5.
        send(0, 8'hA5, n1);
        for (k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 16)  chk("a5_start_end", sig[0], 0);
            if (k == 17)  chk("a5_bit0", sig[0], 1);
            if (k == 33)  chk("a5_bit1", sig[0], 0);
            if (k == 160) chk("a5_stop", sig[0], 1);
            if (!bsy[0]) break;
        end
        chk("a5_busy_fall", k, 161);

        // Back-to-back 8'h3C, 8'hC3.
        send(0, 8'h3C, n1);
        send(0, 8'hC3, n2);
        chk("b2b_second_accept", n2 - n1, 2);
        for (int n = 0; n < 400 && !rdy[0]; n++) @(negedge clk);
        chk("b2b_ready_rise", cyc - n1, 161);
        wait_idle(0, k);
        chk("b2b_busy_fall", cyc - n1, 321);

        // Parity on 8'h07.
        send(1, 8'h07, n1);
        for (k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 153) chk("par_even_bit", sig[1], 1);
            if (!bsy[1]) break;
        end
        chk("par_even_len", k, 177);
        send(2, 8'h07, n1);
        for (k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 153) chk("par_odd_bit", sig[2], 0);
            if (!bsy[2]) break;
        end
        chk("par_odd_len", k, 177);

        // Two stop bits between queued frames.
        send(3, 8'h3C, n1);
        send(3, 8'h5A, n2);
        hi = 0;
        while (cyc < n1 + 177) begin
            @(negedge clk);
            if (cyc == n1 + 144) chk("s2_last_data", sig[3], 0);
            if (cyc >= n1 + 145 && cyc <= n1 + 176 && sig[3]) hi++;
        end
        chk("s2_stop_high", hi, 32);
        chk("s2_next_start", sig[3], 0);
        wait_idle(3, k);

        // Asynchronous reset in the middle of a data bit.
        send(0, 8'hFF, n1);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_sig",   sig[0], 1);
        chk("arst_ready", rdy[0], 1);
        chk("arst_busy",  bsy[0], 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        send(0, 8'h01, n1);
        wait_idle(0, k);
        chk("arst_after_len", k, 161);

        // Random traffic on every configuration.
        for (int i = 0; i < NI; i++) begin
            fork
                automatic int j = i;
                rand_traffic(j);
            join_none
        end
        wait fork;
        repeat (400) @(negedge clk);
        for (int i = 0; i < NI; i++) chk($sformatf("drain_busy%0d", i), bsy[i], 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
